// File: rtl/vending_machine_change_pkg.sv
// Shared state encoding, coin values and coin helpers for vending_machine_change.
package vending_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam int NICKEL_V  = 1;
  localparam int DIME_V    = 2;
  localparam int QUARTER_V = 5;

  typedef struct packed {
    logic nickel;
    logic dime;
    logic quarter;
  } coin_t;

  // Value of a single presented coin; only meaningful when exactly one is high.
  function automatic logic [2:0] coin_value(coin_t c);
    if (c.nickel)       return 3'(NICKEL_V);
    else if (c.dime)    return 3'(DIME_V);
    else if (c.quarter) return 3'(QUARTER_V);
    else                return 3'd0;
  endfunction

  function automatic logic [1:0] coin_count(coin_t c);
    return 2'(c.nickel) + 2'(c.dime) + 2'(c.quarter);
  endfunction

endpackage

// File: rtl/vending_machine_change_if.sv
// Coin/dispense/change bus of vending_machine_change; stock signals exist only
// with VENDING_STOCK_EN. master = coin front end side, slave = controller.
interface vending_machine_change_if #(
  parameter int CREDIT_W = 4
`ifdef VENDING_STOCK_EN
  , parameter int STOCK_W = 4
`endif
);
  logic                io_nickel;
  logic                io_dime;
  logic                io_quarter;
  logic                io_cancel;
  logic                io_ready;
  logic                io_valid;
  logic                io_change;
  logic                io_coin_reject;
  logic [CREDIT_W-1:0] io_credit;
  logic                io_busy;
`ifdef VENDING_STOCK_EN
  logic                io_restock;
  logic [STOCK_W-1:0]  io_restock_count;
  logic                io_empty;
`endif

  modport master (
`ifdef VENDING_STOCK_EN
    output io_restock, io_restock_count,
    input  io_empty,
`endif
    output io_nickel, io_dime, io_quarter, io_cancel, io_ready,
    input  io_valid, io_change, io_coin_reject, io_credit, io_busy
  );

  modport slave (
`ifdef VENDING_STOCK_EN
    input  io_restock, io_restock_count,
    output io_empty,
`endif
    input  io_nickel, io_dime, io_quarter, io_cancel, io_ready,
    output io_valid, io_change, io_coin_reject, io_credit, io_busy
  );

endinterface

// File: rtl/vending_change_counter.sv
// Loadable down-counter driving the nickel change train; pulse while non-zero,
// done marks the cycle of the final pulse.
module vending_change_counter #(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  output logic                pulse,
  output logic                done
);

  logic [CREDIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign pulse = (count != '0);
  assign done  = (count == CREDIT_W'(1));

endmodule

// File: rtl/vending_machine_change.sv
// Vending controller: coin credit, one-item valid/ready dispense, nickel change train.
// Optional stock counter enabled by defining VENDING_STOCK_EN.
module vending_machine_change
  import vending_pkg::*;
#(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 4,
  parameter int STOCK_W  = 4
) (
  input logic                     clk,
  input logic                     reset,
  vending_machine_change_if.slave bus
);

  if (PRICE < 1 || PRICE + 4 >= 2 ** CREDIT_W || STOCK_W < 1) begin : g_bad_cfg
    $error("vending_machine_change: PRICE/CREDIT_W/STOCK_W out of range");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] new_credit;
  logic [CREDIT_W-1:0] load_val;
  coin_t               coin;
  logic                any_coin;
  logic                one_coin;
  logic                stock_ok;
  logic                accept;
  logic                refund;
  logic                handshake;
  logic                load_chg;
  logic                chg_pulse;
  logic                chg_done;

  assign coin      = {bus.io_nickel, bus.io_dime, bus.io_quarter};
  assign any_coin  = (coin != '0);
  assign one_coin  = (coin_count(coin) == 2'd1);
  assign accept    = (state == COLLECT) && one_coin && !bus.io_cancel && stock_ok;
  assign new_credit = credit + CREDIT_W'(coin_value(coin));
  assign refund    = (state == COLLECT) && bus.io_cancel && (credit != '0);
  assign handshake = (state == DISPENSE) && bus.io_ready;

  // Refund and overpayment share one change counter; they never coincide.
  assign load_chg  = refund || (handshake && (credit > PRICE_C));
  assign load_val  = refund ? credit : credit - PRICE_C;

`ifdef VENDING_STOCK_EN
  logic [STOCK_W-1:0] stock;

  always_ff @(posedge clk) begin
    if (reset)                          stock <= '0;
    else if (bus.io_restock)            stock <= bus.io_restock_count;
    else if (handshake && stock != '0)  stock <= stock - 1'b1;
  end

  assign stock_ok     = (stock != '0);
  assign bus.io_empty = !stock_ok;
`else
  assign stock_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= COLLECT;
      credit <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (refund) begin
            credit <= '0;
            state  <= CHANGE;
          end else if (accept) begin
            credit <= new_credit;
            if (new_credit >= PRICE_C) state <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (bus.io_ready) begin
            credit <= '0;
            state  <= (credit > PRICE_C) ? CHANGE : COLLECT;
          end
        end
        CHANGE: begin
          if (chg_done) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  vending_change_counter #(.CREDIT_W(CREDIT_W)) u_change (
    .clk      (clk),
    .reset    (reset),
    .load     (load_chg),
    .load_val (load_val),
    .pulse    (chg_pulse),
    .done     (chg_done)
  );

  assign bus.io_valid       = (state == DISPENSE);
  assign bus.io_change      = (state == CHANGE) && chg_pulse;
  assign bus.io_busy        = (state != COLLECT);
  assign bus.io_credit      = credit;
  assign bus.io_coin_reject = any_coin && !accept;

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed plus randomized bench for vending_machine_change against a money-level
// reference (credit held, nickels owed, sale outstanding).
module tb_vending_machine_change;
  import vending_pkg::*;

  localparam int PRICE    = 4;
  localparam int CREDIT_W = 4;
  localparam int STOCK_W  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef VENDING_STOCK_EN
  vending_machine_change_if #(.CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W)) bus ();
`else
  vending_machine_change_if #(.CREDIT_W(CREDIT_W)) bus ();
`endif

  vending_machine_change #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int m_credit, m_owed, m_stock;
  bit m_sale;
  int pulses, paid, sold_obs;
  bit last_rej;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_owed   = 0;
    m_sale   = 1'b0;
    m_stock  = 0;
  endtask

  function automatic bit stock_ok();
`ifdef VENDING_STOCK_EN
    return m_stock != 0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the reference.
  task automatic tick(input bit n, input bit d, input bit q, input bit c, input bit r,
                      input bit rs = 1'b0);
    int coins, val;
    bit acc;
    bus.io_nickel  = n;
    bus.io_dime    = d;
    bus.io_quarter = q;
    bus.io_cancel  = c;
    bus.io_ready   = r;
    reset          = rs;
    coins = int'(n) + int'(d) + int'(q);
    val   = int'(n) * NICKEL_V + int'(d) * DIME_V + int'(q) * QUARTER_V;
    acc   = (coins == 1) && !c && !m_sale && (m_owed == 0) && stock_ok();
    @(negedge clk);
    chk("valid",  32'(bus.io_valid),       32'(m_sale));
    chk("change", 32'(bus.io_change),      32'(m_owed > 0 && !m_sale));
    chk("busy",   32'(bus.io_busy),        32'(m_sale || m_owed > 0));
    chk("credit", 32'(bus.io_credit),      32'(m_credit));
    chk("reject", 32'(bus.io_coin_reject), 32'(coins > 0 && !acc));
`ifdef VENDING_STOCK_EN
    chk("empty",  32'(bus.io_empty),       32'(m_stock == 0));
`endif
    last_rej = bus.io_coin_reject;
    if (bus.io_change) pulses++;
    if (bus.io_valid && r) sold_obs++;
    @(posedge clk);
    #1;
    if (rs) begin
      model_reset();
    end else begin
`ifdef VENDING_STOCK_EN
      if (bus.io_restock) m_stock = int'(bus.io_restock_count);
      else if (m_sale && r && m_stock > 0) m_stock--;
`endif
      if (m_sale) begin
        if (r) begin
          m_owed   = m_credit - PRICE;
          m_credit = 0;
          m_sale   = 1'b0;
        end
      end else if (m_owed > 0) begin
        m_owed--;
      end else if (c) begin
        if (m_credit > 0) begin
          m_owed   = m_credit;
          m_credit = 0;
        end
      end else if (acc) begin
        m_credit += val;
        paid     += val;
        if (m_credit >= PRICE) m_sale = 1'b1;
      end
    end
  endtask

`ifdef VENDING_STOCK_EN
  task automatic restock(input int cnt);
    bus.io_restock       = 1'b1;
    bus.io_restock_count = STOCK_W'(cnt);
    tick(0, 0, 0, 0, 0);
    bus.io_restock       = 1'b0;
  endtask
`endif

  initial begin
    int k;
    bit rn, rd, rq, rc, rr;
    bus.io_nickel  = 1'b0;
    bus.io_dime    = 1'b0;
    bus.io_quarter = 1'b0;
    bus.io_cancel  = 1'b0;
    bus.io_ready   = 1'b0;
`ifdef VENDING_STOCK_EN
    bus.io_restock       = 1'b0;
    bus.io_restock_count = '0;
`endif
    model_reset();
    paid = 0; sold_obs = 0; pulses = 0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid",  32'(bus.io_valid),       32'd0);
    chk("rst_change", 32'(bus.io_change),      32'd0);
    chk("rst_busy",   32'(bus.io_busy),        32'd0);
    chk("rst_reject", 32'(bus.io_coin_reject), 32'd0);
    chk("rst_credit", 32'(bus.io_credit),      32'd0);
`ifdef VENDING_STOCK_EN
    restock(15);
`endif

    // dime, dime: exact price, no change
    tick(0, 1, 0, 0, 0);
    chk("t1_credit2", 32'(bus.io_credit), 32'd2);
    tick(0, 1, 0, 0, 0);
    chk("t1_credit4", 32'(bus.io_credit), 32'd4);
    chk("t1_valid",   32'(bus.io_valid),  32'd1);
    pulses = 0;
    tick(0, 0, 0, 0, 1);
    chk("t1_idle", 32'(bus.io_busy), 32'd0);
    tick(0, 0, 0, 0, 0);
    chk("t1_pulses", 32'(pulses), 32'd0);

    // quarter with stalled dispenser, one nickel back
    tick(0, 0, 1, 0, 0);
    chk("t2_valid", 32'(bus.io_valid), 32'd1);
    repeat (3) tick(0, 0, 0, 0, 0);
    chk("t2_valid_held", 32'(bus.io_valid), 32'd1);
    pulses = 0;
    tick(0, 0, 0, 0, 1);
    chk("t2_in_change", 32'(bus.io_change), 32'd1);
    repeat (3) tick(0, 0, 0, 0, 0);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_credit", 32'(bus.io_credit), 32'd0);

    // nickel x3 + quarter = 8, four nickels back
    repeat (3) tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("t3_credit8", 32'(bus.io_credit), 32'd8);
    pulses = 0;
    tick(0, 0, 0, 0, 1);
    repeat (6) tick(0, 0, 0, 0, 0);
    chk("t3_pulses", 32'(pulses), 32'd4);

    // refund of 3, dime during the change train is rejected
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("t4_credit3", 32'(bus.io_credit), 32'd3);
    pulses = 0;
    tick(0, 0, 0, 1, 0);
    chk("t4_no_valid", 32'(bus.io_valid), 32'd0);
    tick(0, 1, 0, 0, 0);
    chk("t4_reject", 32'(last_rej), 32'd1);
    chk("t4_credit", 32'(bus.io_credit), 32'd0);
    repeat (4) tick(0, 0, 0, 0, 0);
    chk("t4_pulses", 32'(pulses), 32'd3);

    // two coins at once, then reset mid change train
    tick(1, 1, 0, 0, 0);
    chk("t5_multi_rej", 32'(last_rej), 32'd1);
    chk("t5_credit", 32'(bus.io_credit), 32'd0);
    repeat (3) tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1);
    pulses = 0;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("t5_rst_change", 32'(bus.io_change), 32'd0);
    chk("t5_rst_credit", 32'(bus.io_credit), 32'd0);
    tick(0, 0, 0, 0, 0);
    chk("t5_pulses", 32'(pulses), 32'd2);

`ifdef VENDING_STOCK_EN
    restock(1);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("t6_empty", 32'(bus.io_empty), 32'd1);
    repeat (2) tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("t6_reject", 32'(last_rej), 32'd1);
    restock(15);
`endif

    // randomized traffic, then money conservation once drained
    paid = 0; sold_obs = 0; pulses = 0;
    repeat (400) begin
      k  = int'($urandom_range(0, 11));
      rn = (k == 3) || (k == 9);
      rd = (k == 4) || (k == 9) || (k == 10);
      rq = (k == 5) || (k == 10) || (k == 11);
      rc = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 1) == 1);
`ifdef VENDING_STOCK_EN
      if ($urandom_range(0, 39) == 0) begin
        bus.io_restock       = 1'b1;
        bus.io_restock_count = STOCK_W'($urandom_range(0, 15));
      end
`endif
      tick(rn, rd, rq, rc, rr);
`ifdef VENDING_STOCK_EN
      bus.io_restock = 1'b0;
`endif
    end
    repeat (30) tick(0, 0, 0, 0, 1);
    chk("drain_busy", 32'(bus.io_busy), 32'd0);
    chk("money", 32'(sold_obs * PRICE + pulses + int'(bus.io_credit)), 32'(paid));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
